// File: rtl/div_sched_pkg.sv
// -----------------------------------------------------------------------------
// div_sched_pkg
// Shared types and constants for the divide scheduler slice.
//   sched_state_t : scheduler FSM states (IDLE, BUSY, DONE)
//   slot_idx_t    : issue-slot index (0 = master/older, 1 = slave)
//   DIV_DATA_W    : default operand width
//   ALUOP_DIV/U   : divide aluop encodings, kept identical to defines.vh
// -----------------------------------------------------------------------------
package div_sched_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic [7:0] ALUOP_DIV  = 8'h1a;
  localparam logic [7:0] ALUOP_DIVU = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  typedef logic [0:0] slot_idx_t;

  // One-hot done vector for a slot index.
  function automatic logic [1:0] slot_onehot(input slot_idx_t slot);
    return (slot == 1'b1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// -----------------------------------------------------------------------------
// div_result_cache
// Single-entry memo of the last completed divide. Used by div_sched only when
// DIV_RESULT_CACHE_EN is defined.
// Ports:
//   clk, rst               clock, async active-low reset (invalidates entry)
//   wr_en                  store wr_a/wr_b/wr_signed/wr_result as the entry
//   wr_a, wr_b, wr_signed  operands of the divide that just completed
//   wr_result              its {remainder, quotient}
//   inval                  drop the entry (pipeline flush)
//   lk_a, lk_b, lk_signed  lookup key (operands of the slot being granted)
//   hit                    lookup key matches a valid entry
//   hit_result             stored result for the entry
// -----------------------------------------------------------------------------
module div_result_cache
  import div_sched_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_a,
  input  logic [DATA_W-1:0]   wr_b,
  input  logic                wr_signed,
  input  logic [2*DATA_W-1:0] wr_result,
  input  logic                inval,
  input  logic [DATA_W-1:0]   lk_a,
  input  logic [DATA_W-1:0]   lk_b,
  input  logic                lk_signed,
  output logic                hit,
  output logic [2*DATA_W-1:0] hit_result
);

  logic                valid_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                signed_q;
  logic [2*DATA_W-1:0] result_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else if (inval) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: the payload has no reset; valid_q alone decides whether it is used,
  // so resetting these wide registers would only cost reset routing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_q      <= wr_a;
      b_q      <= wr_b;
      signed_q <= wr_signed;
      result_q <= wr_result;
    end
  end

  assign hit        = valid_q && (lk_a == a_q) && (lk_b == b_q) && (lk_signed == signed_q);
  assign hit_result = result_q;

endmodule

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// Shares one iterative divider between the master (slot 0) and slave (slot 1)
// ALU issue slots. Grants the lowest requesting slot, latches its operands,
// runs the divider start/annul/ready handshake and returns {hi,lo} to the
// owner with a one-cycle done pulse. Flush kills a divide in flight.
// Optional feature macro: DIV_RESULT_CACHE_EN (repeat of the last completed
// divide completes without using the divider).
// Ports:
//   clk, rst                 clock, async active-low reset
//   req_valid[1:0]           per-slot request, held until that slot's done
//   req_op0/1                aluop per slot (DIV signed, DIVU unsigned)
//   req_a0/b0, req_a1/b1     dividend/divisor per slot
//   flush                    kill in-flight or pending divide
//   done[1:0]                one-hot completion pulse to the owning slot
//   result                   {remainder, quotient}, zero outside done
//   busy                     scheduler not in IDLE
//   div_start/signed/annul   divider control
//   div_a, div_b             registered divider operands
//   div_result, div_ready    divider response
// -----------------------------------------------------------------------------
module div_sched
  import div_sched_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [7:0]          req_op0,
  input  logic [7:0]          req_op1,
  input  logic [DATA_W-1:0]   req_a0,
  input  logic [DATA_W-1:0]   req_b0,
  input  logic [DATA_W-1:0]   req_a1,
  input  logic [DATA_W-1:0]   req_b1,
  input  logic                flush,
  output logic [1:0]          done,
  output logic [2*DATA_W-1:0] result,
  output logic                busy,
  output logic                div_start,
  output logic                div_signed,
  output logic                div_annul,
  output logic [DATA_W-1:0]   div_a,
  output logic [DATA_W-1:0]   div_b,
  input  logic [2*DATA_W-1:0] div_result,
  input  logic                div_ready
);

  sched_state_t        state_q, state_d;
  slot_idx_t           owner_q;
  slot_idx_t           grant_slot;
  logic                grant;
  logic [DATA_W-1:0]   grant_a;
  logic [DATA_W-1:0]   grant_b;
  logic                grant_signed;
  logic                div_complete;
  logic [2*DATA_W-1:0] result_q;
  logic                cache_hit;
  logic [2*DATA_W-1:0] cache_result;

  // Grant selection: master wins a tie; a flush in IDLE suppresses the grant.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_slot   = req_valid[0] ? 1'b0 : 1'b1;
    grant        = (state_q == IDLE) && (|req_valid) && !flush;
    grant_a      = grant_slot[0] ? req_a1 : req_a0;
    grant_b      = grant_slot[0] ? req_b1 : req_b0;
    grant_signed = ((grant_slot[0] ? req_op1 : req_op0) == ALUOP_DIV);
  end

  // A ready that coincides with a flush belongs to a killed instruction.
  assign div_complete = (state_q == BUSY) && div_ready && !flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = cache_hit ? DONE : BUSY;
      BUSY:    if (flush) state_d = IDLE;
               else if (div_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      div_a      <= '0;
      div_b      <= '0;
      div_signed <= 1'b0;
      div_annul  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_annul <= (state_q == BUSY) && flush;
      if (grant) begin
        owner_q    <= grant_slot;
        div_a      <= grant_a;
        div_b      <= grant_b;
        div_signed <= grant_signed;
        if (cache_hit) result_q <= cache_result;
      end
      if (div_complete) result_q <= div_result;
    end
  end

  // Operands stay stable in div_a/div_b for the whole BUSY stretch because
  // they are only reloaded on a grant, which happens in IDLE.
  assign div_start = (state_q == BUSY);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) ? slot_onehot(owner_q) : 2'b00;
  assign result    = (state_q == DONE) ? result_q : '0;

`ifdef DIV_RESULT_CACHE_EN
  div_result_cache #(
    .DATA_W (DATA_W)
  ) u_cache (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (div_complete),
    .wr_a       (div_a),
    .wr_b       (div_b),
    .wr_signed  (div_signed),
    .wr_result  (div_result),
    .inval      (flush),
    .lk_a       (grant_a),
    .lk_b       (grant_b),
    .lk_signed  (grant_signed),
    .hit        (cache_hit),
    .hit_result (cache_result)
  );
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // The owning slot must hold its request for the whole divide unless a
  // flush is what removes it.
  a_req_held: assert property (@(posedge clk) disable iff (!rst)
    ((state_q == BUSY) && !flush) |-> req_valid[owner_q])
    else $error("div_sched: owner request dropped during BUSY without flush");

endmodule
